// File: rtl/spi_reg_pkg.sv
// Shared definitions for the SPI register bank.
// Contents: FSM state enum, the R/nW encoding for writes, and a helper
// function that returns the frame length in bits.
package spi_reg_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StCmd,
        StData,
        StWaitCs
    } state_e;

    // The value of the first frame bit that marks a write.
    localparam logic RW_WRITE = 1'b1;

    // Frame length in bits: the R/nW bit, then the address, then the data.
    function automatic int unsigned frame_len(input int unsigned addr_w,
                                              input int unsigned data_w);
        return 1 + addr_w + data_w;
    endfunction

endpackage

// File: rtl/spi_reg_bank_if.sv
// SPI pin bundle between an external controller and the register bank.
//   sclk, ncs, copi : driven by the controller (master)
//   cipo, cipo_oe   : driven by the peripheral (slave)
interface spi_reg_bank_if;
    logic sclk;
    logic ncs;
    logic copi;
    logic cipo;
    logic cipo_oe;

    modport master (output sclk, output ncs, output copi, input cipo, input cipo_oe);
    modport slave  (input sclk, input ncs, input copi, output cipo, output cipo_oe);
endinterface

// File: rtl/spi_sync_edge.sv
// Two-flop synchroniser for an asynchronous input, with edge detect on the
// synchronised value.
// Ports: clk, rst (synchronous, active-high), din (async input),
//        q (synchronised level), rise/fall (one-cycle edge pulses).
// IDLE sets the level that the flops take during reset.
module spi_sync_edge #(
    parameter logic IDLE = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic q,
    output logic rise,
    output logic fall
);
    logic [1:0] sync_q;
    logic       prev_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= {2{IDLE}};
            prev_q <= IDLE;
        end else begin
            sync_q <= {sync_q[0], din};
            prev_q <= sync_q[1];
        end
    end

    assign q    = sync_q[1];
    assign rise = q & ~prev_q;
    assign fall = ~q & prev_q;
endmodule

// File: rtl/spi_reg_bank.sv
// SPI mode-0 peripheral that exposes NUM_REGS registers of DATA_W bits.
// Frame layout, MSB first: R/nW (1 = write), ADDR_W address bits, then
// DATA_W data bits. Read data is shifted out on cipo.
// Ports: clk, rst (synchronous, active-high), spi (slave modport:
//        sclk/ncs/copi in, cipo/cipo_oe out), regs_flat (register i at
//        [i*DATA_W +: DATA_W]), wr_stb (write pulse), wr_addr (address of the
//        last committed write), frame_err (aborted-frame pulse).
// Optional macro SPI_BURST_EN: the address auto-increments after each word
// and the frame may carry several words.
module spi_reg_bank
    import spi_reg_pkg::*;
#(
    parameter int unsigned       NUM_REGS  = 5,
    parameter int unsigned       ADDR_W    = 7,
    parameter int unsigned       DATA_W    = 8,
    parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
    input  logic                       clk,
    input  logic                       rst,
    spi_reg_bank_if.slave              spi,
    output logic [NUM_REGS*DATA_W-1:0] regs_flat,
    output logic                       wr_stb,
    output logic [ADDR_W-1:0]          wr_addr,
    output logic                       frame_err
);
    localparam int unsigned CMD_BITS = frame_len(ADDR_W, DATA_W) - DATA_W;
    localparam int unsigned CNT_MAX  = (CMD_BITS > DATA_W) ? CMD_BITS : DATA_W;
    localparam int unsigned CNT_W    = $clog2(CNT_MAX + 1);

    logic sclk_rise, sclk_fall, sclk_s;
    logic ncs_s, ncs_rise, ncs_fall;
    logic [1:0] copi_q;
    logic copi_s;

    spi_sync_edge #(.IDLE(1'b0)) u_sclk_sync (
        .clk (clk),
        .rst (rst),
        .din (spi.sclk),
        .q   (sclk_s),
        .rise(sclk_rise),
        .fall(sclk_fall)
    );

    spi_sync_edge #(.IDLE(1'b1)) u_ncs_sync (
        .clk (clk),
        .rst (rst),
        .din (spi.ncs),
        .q   (ncs_s),
        .rise(ncs_rise),
        .fall(ncs_fall)
    );

    always_ff @(posedge clk) begin
        if (rst) copi_q <= 2'b00;
        else     copi_q <= {copi_q[0], spi.copi};
    end
    assign copi_s = copi_q[1];

    state_e              state_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [ADDR_W-1:0]   cmd_sr_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [ADDR_W-1:0]   cm_addr_q;
    logic                rw_q;
    logic [DATA_W-1:0]   data_sr_q;
    logic [DATA_W-1:0]   tx_sr_q;
    logic                commit_q;
    logic                cipo_q;
    logic                cipo_oe_q;
    logic                armed_q;
    logic [1:0]          arm_cnt_q;
    logic [DATA_W-1:0]   regs_q [NUM_REGS];

    logic [ADDR_W:0]     cmd_full;
    logic [DATA_W-1:0]   data_full;
    logic [DATA_W-1:0]   rd_cmd;
    logic                frame_open;

    function automatic logic [DATA_W-1:0] read_reg(input logic [ADDR_W-1:0] a);
        read_reg = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (a == ADDR_W'(i)) read_reg = regs_q[i];
        end
    endfunction

    assign cmd_full  = {cmd_sr_q, copi_s};
    assign data_full = {data_sr_q[DATA_W-2:0], copi_s};
    assign rd_cmd    = read_reg(cmd_full[ADDR_W-1:0]);

`ifdef SPI_BURST_EN
    logic              word_done_q;
    logic [DATA_W-1:0] rd_inc;
    assign rd_inc     = read_reg(addr_q + 1'b1);
    // Only a partial word, or no complete word at all, counts as an abort.
    assign frame_open = (state_q == StCmd) ||
                        ((state_q == StData) && ((cnt_q != '0) || !word_done_q));
`else
    assign frame_open = (state_q == StCmd) || (state_q == StData);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            cmd_sr_q  <= '0;
            addr_q    <= '0;
            cm_addr_q <= '0;
            rw_q      <= 1'b0;
            data_sr_q <= '0;
            tx_sr_q   <= '0;
            commit_q  <= 1'b0;
            cipo_q    <= 1'b0;
            cipo_oe_q <= 1'b0;
            armed_q   <= 1'b0;
            arm_cnt_q <= 2'd0;
            wr_stb    <= 1'b0;
            wr_addr   <= '0;
            frame_err <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= RESET_VAL;
`ifdef SPI_BURST_EN
            word_done_q <= 1'b0;
`endif
        end else begin
            wr_stb    <= 1'b0;
            frame_err <= 1'b0;
            cipo_oe_q <= ~ncs_s;

            // The write lands one cycle after its last data bit was sampled.
            if (commit_q) begin
                commit_q <= 1'b0;
                wr_stb   <= 1'b1;
                wr_addr  <= cm_addr_q;
                for (int i = 0; i < NUM_REGS; i++) begin
                    if (cm_addr_q == ADDR_W'(i)) regs_q[i] <= data_sr_q;
                end
            end

            // After reset the synchroniser reads as ncs high for two cycles,
            // even while ncs is held low. Require three consecutive high cycles
            // so a frame cut by reset cannot restart until ncs really idles.
            if (!armed_q) begin
                if (ncs_s) begin
                    if (arm_cnt_q == 2'd2) armed_q <= 1'b1;
                    arm_cnt_q <= arm_cnt_q + 2'd1;
                end else begin
                    arm_cnt_q <= 2'd0;
                end
            end

            if (ncs_rise) begin
                // ncs takes priority over an sclk rise in the same cycle.
                if (frame_open) frame_err <= 1'b1;
                state_q <= StIdle;
                cipo_q  <= 1'b0;
            end else begin
                case (state_q)
                    StIdle: begin
                        if (ncs_fall && armed_q) begin
                            state_q <= StCmd;
                            cnt_q   <= '0;
`ifdef SPI_BURST_EN
                            word_done_q <= 1'b0;
`endif
                        end
                    end
                    StCmd: begin
                        if (sclk_rise) begin
                            cmd_sr_q <= cmd_full[ADDR_W-1:0];
                            if (cnt_q == CNT_W'(CMD_BITS - 1)) begin
                                state_q <= StData;
                                cnt_q   <= '0;
                                rw_q    <= cmd_full[ADDR_W];
                                addr_q  <= cmd_full[ADDR_W-1:0];
                                tx_sr_q <= rd_cmd;
                            end else begin
                                cnt_q <= cnt_q + 1'b1;
                            end
                        end
                    end
                    StData: begin
                        if (sclk_rise) begin
                            data_sr_q <= data_full;
                            if (cnt_q == CNT_W'(DATA_W - 1)) begin
                                cnt_q <= '0;
                                if ((rw_q == RW_WRITE) &&
                                    ({1'b0, addr_q} < (ADDR_W + 1)'(NUM_REGS))) begin
                                    commit_q  <= 1'b1;
                                    cm_addr_q <= addr_q;
                                end
`ifdef SPI_BURST_EN
                                addr_q      <= addr_q + 1'b1;
                                tx_sr_q     <= rd_inc;
                                word_done_q <= 1'b1;
`else
                                state_q <= StWaitCs;
                                cipo_q  <= 1'b0;
`endif
                            end else begin
                                cnt_q <= cnt_q + 1'b1;
                            end
                        end else if (sclk_fall) begin
                            cipo_q  <= tx_sr_q[DATA_W-1];
                            tx_sr_q <= {tx_sr_q[DATA_W-2:0], 1'b0};
                        end
                    end
                    StWaitCs: ;
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

    assign spi.cipo    = cipo_q;
    assign spi.cipo_oe = cipo_oe_q;

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
        assign regs_flat[g*DATA_W +: DATA_W] = regs_q[g];
    end

    // The synchronised sclk level is only needed for its edges.
    logic unused_sclk;
    assign unused_sclk = sclk_s;
endmodule

// File: tb/tb_spi_reg_bank.sv
// Directed testbench for spi_reg_bank: acts as a mode-0 SPI controller,
// compares register contents, strobes and read data to hand-computed values.
module tb_spi_reg_bank;
    logic        clk;
    logic        rst;
    logic [39:0] regs_flat;
    logic        wr_stb;
    logic [6:0]  wr_addr;
    logic        frame_err;

    spi_reg_bank_if spi ();

    spi_reg_bank u_dut (
        .clk      (clk),
        .rst      (rst),
        .spi      (spi),
        .regs_flat(regs_flat),
        .wr_stb   (wr_stb),
        .wr_addr  (wr_addr),
        .frame_err(frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int stb_cnt = 0;
    int err_cnt = 0;
    int stb_base;
    int err_base;
    logic oe_ok;
    logic [63:0] rx;

    always @(posedge clk) begin
        if (wr_stb)    stb_cnt++;
        if (frame_err) err_cnt++;
    end

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic cs_low();
        spi.ncs = 1'b0;
        wait_clks(8);
    endtask

    task automatic cs_high();
        wait_clks(8);
        spi.ncs = 1'b1;
        wait_clks(12);
    endtask

    // Shift out the n low bits of tx MSB first; cipo is sampled at each rise.
    task automatic spi_xfer(input logic [63:0] tx, input int n, output logic [63:0] rxd);
        rxd = '0;
        for (int i = n - 1; i >= 0; i--) begin
            spi.copi = tx[i];
            wait_clks(8);
            spi.sclk = 1'b1;
            rxd = {rxd[62:0], spi.cipo};
            if (!spi.cipo_oe) oe_ok = 1'b0;
            wait_clks(8);
            spi.sclk = 1'b0;
        end
    endtask

    task automatic spi_frame(input logic rw, input logic [6:0] addr, input logic [7:0] data);
        cs_low();
        spi_xfer({48'h0, rw, addr, data}, 16, rx);
        cs_high();
    endtask

    initial begin
        spi.sclk = 1'b0;
        spi.ncs  = 1'b1;
        spi.copi = 1'b0;
        rst = 1'b1;
        wait_clks(5);
        rst = 1'b0;
        wait_clks(10);

        check_val("rst_regs", 64'(regs_flat), 64'h0);
        check_val("rst_wr_stb", 64'(wr_stb), 64'h0);
        check_val("rst_frame_err", 64'(frame_err), 64'h0);
        check_val("rst_wr_addr", 64'(wr_addr), 64'h0);
        check_val("rst_cipo", 64'(spi.cipo), 64'h0);
        check_val("rst_cipo_oe", 64'(spi.cipo_oe), 64'h0);

        // Write register 2.
        stb_base = stb_cnt;
        spi_frame(1'b1, 7'd2, 8'hA5);
        check_val("wr2_regs", 64'(regs_flat), 64'h00_00_A5_00_00);
        check_val("wr2_stb", 64'(stb_cnt - stb_base), 64'd1);
        check_val("wr2_addr", 64'(wr_addr), 64'd2);

        // Write register 4, then read it back.
        spi_frame(1'b1, 7'd4, 8'h3C);
        check_val("wr4_regs", 64'(regs_flat), 64'h3C_00_A5_00_00);
        check_val("wr4_addr", 64'(wr_addr), 64'd4);
        oe_ok = 1'b1;
        stb_base = stb_cnt;
        spi_frame(1'b0, 7'd4, 8'h00);
        check_val("rd4_data", 64'(rx[7:0]), 64'h3C);
        check_val("rd4_oe", 64'(oe_ok), 64'h1);
        check_val("rd4_no_stb", 64'(stb_cnt - stb_base), 64'd0);
        check_val("rd4_cipo_idle", 64'(spi.cipo), 64'h0);
        check_val("idle_oe", 64'(spi.cipo_oe), 64'h0);

        // Out-of-range write and read.
        stb_base = stb_cnt;
        spi_frame(1'b1, 7'h10, 8'h55);
        check_val("oor_wr_regs", 64'(regs_flat), 64'h3C_00_A5_00_00);
        check_val("oor_wr_stb", 64'(stb_cnt - stb_base), 64'd0);
        check_val("oor_wr_addr", 64'(wr_addr), 64'd4);
        spi_frame(1'b0, 7'h10, 8'hFF);
        check_val("oor_rd_data", 64'(rx[7:0]), 64'h00);

        // Abort after 12 bits of a write.
        stb_base = stb_cnt;
        err_base = err_cnt;
        cs_low();
        spi_xfer({52'h0, 1'b1, 7'd1, 4'hF}, 12, rx);
        cs_high();
        check_val("abort_err", 64'(err_cnt - err_base), 64'd1);
        check_val("abort_regs", 64'(regs_flat), 64'h3C_00_A5_00_00);
        check_val("abort_stb", 64'(stb_cnt - stb_base), 64'd0);
        err_base = err_cnt;
        spi_frame(1'b1, 7'd0, 8'h77);
        check_val("after_abort_regs", 64'(regs_flat), 64'h3C_00_A5_00_77);
        check_val("after_abort_err", 64'(err_cnt - err_base), 64'd0);

        // Reset in the middle of a write frame; the rest of it must be ignored.
        cs_low();
        spi_xfer({58'h0, 1'b1, 5'd0}, 6, rx);
        rst = 1'b1;
        wait_clks(3);
        rst = 1'b0;
        stb_base = stb_cnt;
        err_base = err_cnt;
        spi_xfer({54'h0, 2'd1, 8'h99}, 10, rx);
        cs_high();
        check_val("midrst_regs", 64'(regs_flat), 64'h0);
        check_val("midrst_stb", 64'(stb_cnt - stb_base), 64'd0);
        check_val("midrst_err", 64'(err_cnt - err_base), 64'd0);
        check_val("midrst_addr", 64'(wr_addr), 64'd0);
        spi_frame(1'b1, 7'd1, 8'h99);
        check_val("post_rst_regs", 64'(regs_flat), 64'h00_00_00_99_00);
        check_val("post_rst_addr", 64'(wr_addr), 64'd1);

`ifdef SPI_BURST_EN
        stb_base = stb_cnt;
        err_base = err_cnt;
        cs_low();
        spi_xfer({32'h0, 1'b1, 7'd0, 8'h11, 8'h22, 8'h33}, 32, rx);
        cs_high();
        check_val("burst_regs", 64'(regs_flat), 64'h00_00_33_22_11);
        check_val("burst_stb", 64'(stb_cnt - stb_base), 64'd3);
        check_val("burst_err", 64'(err_cnt - err_base), 64'd0);
        check_val("burst_addr", 64'(wr_addr), 64'd2);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
